// File: rtl/knn_sdram_pkg.sv
// Shared types and defaults for the KNN SDRAM port arbiter.
package knn_sdram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam int RD_LAT_DEF    = 4;
    localparam int WR_CYCLES_DEF = 9;

    localparam int CLIENT0 = 0;
    localparam int CLIENT1 = 1;

endpackage

// File: rtl/knn_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last client served.
module knn_rr_arb2
    import knn_sdram_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt_onehot
);

    logic r_last;
    logic w_pick;

    always_comb begin
        w_pick       = 1'(CLIENT0);
        o_gnt_onehot = '0;
        if (i_req == 2'b10 || (i_req == 2'b11 && r_last == 1'(CLIENT0))) begin
            w_pick = 1'(CLIENT1);
        end
        if (|i_req) begin
            o_gnt_onehot[w_pick] = 1'b1;
        end
    end

    // Pointer starts at client 1 so client 0 wins the first contested grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'(CLIENT1);
        end else if (i_advance) begin
            r_last <= w_pick;
        end
    end

endmodule

// File: rtl/knn_sdram_arbiter.sv
// Shares one SDRAM master port between two clients with round-robin grants,
// fixed-latency read capture and fixed-length write occupancy.
module knn_sdram_arbiter
    import knn_sdram_pkg::*;
#(
    parameter int W         = 16,
    parameter int ADDR_W    = 25,
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int WR_CYCLES = WR_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [W-1:0]      c0_wdata,
    output logic              c0_gnt,
    output logic              c0_rvalid,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [W-1:0]      c1_wdata,
    output logic              c1_gnt,
    output logic              c1_rvalid,
    output logic [W-1:0]      rdata,
    output logic              busy,
    output logic              read,
    output logic [ADDR_W-1:0] readaddress,
    input  logic [W-1:0]      readdata,
    output logic              write,
    output logic [ADDR_W-1:0] writeaddress,
    output logic [W-1:0]      writedata
);

    localparam int CNT_MAX = (RD_LAT > WR_CYCLES) ? RD_LAT : WR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt_oh;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rvalid;
    logic              w_issue;
    logic              w_capture;
    logic              w_win;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [W-1:0]      w_win_wdata;
    logic              r_owner;
    logic              r_read;
    logic              r_write;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_waddr;
    logic [W-1:0]      r_wdata;
    logic [W-1:0]      r_rdata;

    assign w_req = {c1_req, c0_req};

    knn_rr_arb2 u_arb (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (w_req),
        .i_advance    (w_issue),
        .o_gnt_onehot (w_gnt_oh)
    );

    assign w_win       = w_gnt_oh[CLIENT1];
    assign w_win_we    = w_win ? c1_we    : c0_we;
    assign w_win_addr  = w_win ? c1_addr  : c0_addr;
    assign w_win_wdata = w_win ? c1_wdata : c0_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_issue     = 1'b1;
                    w_state_nxt = w_win_we ? WR_WAIT : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (r_cnt == CNT_W'(RD_LAT)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WR_WAIT: begin
                if (r_cnt == CNT_W'(WR_CYCLES)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter is 1 after the assert edge, so cnt == N marks the N-th edge after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_owner  <= 1'b0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_raddr  <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            if (w_issue) begin
                r_gnt   <= w_gnt_oh;
                r_owner <= w_win;
                r_cnt   <= CNT_W'(1);
                if (w_win_we) begin
                    r_write <= 1'b1;
                    r_waddr <= w_win_addr;
                    r_wdata <= w_win_wdata;
                end else begin
                    r_read  <= 1'b1;
                    r_raddr <= w_win_addr;
                end
            end else if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_rdata           <= readdata;
                r_rvalid[r_owner] <= 1'b1;
            end
        end
    end

    assign c0_gnt       = r_gnt[CLIENT0];
    assign c1_gnt       = r_gnt[CLIENT1];
    assign c0_rvalid    = r_rvalid[CLIENT0];
    assign c1_rvalid    = r_rvalid[CLIENT1];
    assign rdata        = r_rdata;
    assign busy         = (r_state != IDLE);
    assign read         = r_read;
    assign readaddress  = r_raddr;
    assign write        = r_write;
    assign writeaddress = r_waddr;
    assign writedata    = r_wdata;

endmodule

// File: tb/tb_knn_sdram_arbiter.sv
// Self-checking bench for knn_sdram_arbiter: transaction-level port model plus scenario tasks.
module tb_knn_sdram_arbiter;

    localparam int W         = 16;
    localparam int AW        = 25;
    localparam int RD_LAT    = 4;
    localparam int WR_CYCLES = 9;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          c0_req = 1'b0, c0_we = 1'b0, c1_req = 1'b0, c1_we = 1'b0;
    logic [AW-1:0] c0_addr = '0, c1_addr = '0;
    logic [W-1:0]  c0_wdata = '0, c1_wdata = '0;
    logic          c0_gnt, c0_rvalid, c1_gnt, c1_rvalid, busy, read, write;
    logic [W-1:0]  rdata, writedata;
    logic [W-1:0]  readdata = '0;
    logic [AW-1:0] readaddress, writeaddress;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    knn_sdram_arbiter #(.W(W), .ADDR_W(AW), .RD_LAT(RD_LAT), .WR_CYCLES(WR_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid),
        .rdata(rdata), .busy(busy),
        .read(read), .readaddress(readaddress), .readdata(readdata),
        .write(write), .writeaddress(writeaddress), .writedata(writedata)
    );

    function automatic logic [W-1:0] mem_f(input logic [AW-1:0] a);
        logic [W-1:0] lo;
        lo = a[W-1:0];
        if (a == 25'h40) return 16'h1234;
        return (lo * 16'd37) + 16'hA5C3;
    endfunction

    // SDRAM side: valid data appears on the 3rd edge after the read strobe edge, junk otherwise.
    int       sd_pend = 0;
    logic [AW-1:0] sd_addr = '0;
    always @(posedge clk) begin
        if (read) begin
            sd_pend  = 2;
            sd_addr  = readaddress;
            readdata <= 16'($urandom);
        end else if (sd_pend > 0) begin
            sd_pend--;
            readdata <= (sd_pend == 0) ? mem_f(sd_addr) : 16'($urandom);
        end else begin
            readdata <= 16'($urandom);
        end
    end

    // Client agents: drop request on grant, then present the next queued command.
    cmd_t q0[$];
    cmd_t q1[$];
    always @(negedge clk) begin
        if (c0_gnt) begin void'(q0.pop_front()); c0_req = 1'b0; end
        if (c1_gnt) begin void'(q1.pop_front()); c1_req = 1'b0; end
        if (!rst && !c0_req && q0.size() > 0) begin
            c0_req = 1'b1; c0_we = q0[0].we; c0_addr = q0[0].addr; c0_wdata = q0[0].wdata;
        end
        if (!rst && !c1_req && q1.size() > 0) begin
            c1_req = 1'b1; c1_we = q1[0].we; c1_addr = q1[0].addr; c1_wdata = q1[0].wdata;
        end
    end

    // Reference model: the port is reserved until a known edge; reads complete RD_LAT edges after issue.
    int unsigned   m_free = 0, m_rd_edge = 0;
    logic          m_rd_pend = 1'b0, m_last = 1'b1, m_rd_owner = 1'b0, win;
    logic [AW-1:0] m_rd_addr = '0, e_raddr = '0, e_waddr = '0;
    logic [W-1:0]  e_rdata = '0, e_wdata = '0;
    logic [1:0]    e_gnt = '0, e_rvalid = '0;
    logic          e_read = 1'b0, e_write = 1'b0, e_busy = 1'b0;
    logic [6:0]    e_ctl = '0;
    logic [81:0]   e_dat = '0;
    always @(posedge clk) begin
        cyc++;
        e_gnt = '0; e_rvalid = '0; e_read = 1'b0; e_write = 1'b0;
        if (rst) begin
            m_free = cyc + 1; m_rd_pend = 1'b0; m_last = 1'b1;
            e_rdata = '0; e_raddr = '0; e_waddr = '0; e_wdata = '0;
        end else begin
            if (m_rd_pend && cyc == m_rd_edge) begin
                e_rvalid[m_rd_owner] = 1'b1;
                e_rdata = mem_f(m_rd_addr);
                m_rd_pend = 1'b0;
            end
            if (cyc >= m_free && (c0_req || c1_req)) begin
                win = (c0_req && c1_req) ? ~m_last : c1_req;
                m_last = win;
                e_gnt[win] = 1'b1;
                if (win ? c1_we : c0_we) begin
                    e_write = 1'b1;
                    e_waddr = win ? c1_addr : c0_addr;
                    e_wdata = win ? c1_wdata : c0_wdata;
                    m_free  = cyc + WR_CYCLES + 1;
                end else begin
                    e_read     = 1'b1;
                    e_raddr    = win ? c1_addr : c0_addr;
                    m_rd_pend  = 1'b1;
                    m_rd_edge  = cyc + RD_LAT;
                    m_rd_owner = win;
                    m_rd_addr  = e_raddr;
                    m_free     = cyc + RD_LAT + 1;
                end
            end
        end
        e_busy = (cyc + 1 < m_free);
        e_ctl  = {e_gnt, e_rvalid, e_read, e_write, e_busy};
        e_dat  = {e_rdata, e_raddr, e_waddr, e_wdata};
    end

    wire [6:0]  obs_ctl = {c1_gnt, c0_gnt, c1_rvalid, c0_rvalid, read, write, busy};
    wire [81:0] obs_dat = {rdata, readaddress, writeaddress, writedata};

    // Event log of observed strobes, for timing and ordering checks.
    int unsigned gnt_cyc[$], rd_cyc[$], wr_cyc[$], rv_cyc[$];
    int unsigned gnt_who[$], rv_who[$];
    logic [W-1:0] rv_data[$];
    int unsigned busy_cnt = 0;
    always @(negedge clk) begin
        if (c0_gnt) begin gnt_cyc.push_back(cyc); gnt_who.push_back(0); end
        if (c1_gnt) begin gnt_cyc.push_back(cyc); gnt_who.push_back(1); end
        if (read)  rd_cyc.push_back(cyc);
        if (write) wr_cyc.push_back(cyc);
        if (c0_rvalid) begin rv_cyc.push_back(cyc); rv_who.push_back(0); rv_data.push_back(rdata); end
        if (c1_rvalid) begin rv_cyc.push_back(cyc); rv_who.push_back(1); rv_data.push_back(rdata); end
        if (busy) busy_cnt++;
    end

    task automatic clear_logs();
        gnt_cyc.delete(); gnt_who.delete(); rd_cyc.delete(); wr_cyc.delete();
        rv_cyc.delete(); rv_who.delete(); rv_data.delete(); busy_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        q0.delete(); q1.delete();
        c0_req = 1'b0; c1_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; c0_req = 1'b1; c1_req = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_ctl !== 7'b0) begin
            errors++; $display("FAIL reset_ctl got=%b expected=%b", obs_ctl, 7'b0);
        end
        checks++;
        if (obs_dat !== 82'b0) begin
            errors++; $display("FAIL reset_data got=%h expected=0", obs_dat);
        end
        c0_req = 1'b0; c1_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_read_single();
        cmd_t c;
        clear_logs();
        c.we = 1'b0; c.addr = 25'h40; c.wdata = '0;
        q0.push_back(c);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (obs_ctl !== e_ctl) begin errors++; $display("FAIL read1_ctl cyc=%0d got=%b expected=%b", cyc, obs_ctl, e_ctl); end
            checks++;
            if (obs_dat !== e_dat) begin errors++; $display("FAIL read1_data cyc=%0d got=%h expected=%h", cyc, obs_dat, e_dat); end
        end
        checks++;
        if (rd_cyc.size() != 1 || rv_cyc.size() != 1) begin
            errors++; $display("FAIL read1_count reads=%0d rvalids=%0d expected=1/1", rd_cyc.size(), rv_cyc.size());
        end else begin
            checks++;
            if (rv_cyc[0] - rd_cyc[0] != RD_LAT || rv_who[0] != 0 || rv_data[0] !== 16'h1234) begin
                errors++; $display("FAIL read1_result lat=%0d who=%0d data=%h expected lat=%0d who=0 data=1234",
                                   rv_cyc[0] - rd_cyc[0], rv_who[0], rv_data[0], RD_LAT);
            end
        end
    endtask

    task automatic test_write_single();
        cmd_t c;
        clear_logs();
        c.we = 1'b1; c.addr = 25'h10; c.wdata = 16'hBEEF;
        q0.push_back(c);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checks++;
            if (obs_ctl !== e_ctl) begin errors++; $display("FAIL write1_ctl cyc=%0d got=%b expected=%b", cyc, obs_ctl, e_ctl); end
            checks++;
            if (obs_dat !== e_dat) begin errors++; $display("FAIL write1_data cyc=%0d got=%h expected=%h", cyc, obs_dat, e_dat); end
        end
        checks++;
        if (wr_cyc.size() != 1 || busy_cnt != WR_CYCLES || writeaddress !== 25'h10 || writedata !== 16'hBEEF) begin
            errors++; $display("FAIL write1_result writes=%0d busy=%0d addr=%h data=%h expected 1/%0d/10/beef",
                               wr_cyc.size(), busy_cnt, writeaddress, writedata, WR_CYCLES);
        end
    endtask

    task automatic test_both_read();
        cmd_t c;
        do_reset();
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            c.we = 1'b0; c.wdata = '0;
            c.addr = 25'($urandom); q0.push_back(c);
            c.addr = 25'($urandom); q1.push_back(c);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (obs_ctl !== e_ctl) begin errors++; $display("FAIL both_ctl cyc=%0d got=%b expected=%b", cyc, obs_ctl, e_ctl); end
            checks++;
            if (obs_dat !== e_dat) begin errors++; $display("FAIL both_data cyc=%0d got=%h expected=%h", cyc, obs_dat, e_dat); end
        end
        checks++;
        if (gnt_who.size() != 6 || rv_who.size() != 6) begin
            errors++; $display("FAIL both_count grants=%0d rvalids=%0d expected=6/6", gnt_who.size(), rv_who.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (gnt_who[i] != i % 2 || rv_who[i] != i % 2) begin
                    errors++; $display("FAIL both_order idx=%0d gnt=%0d rvalid=%0d expected=%0d", i, gnt_who[i], rv_who[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_wr_then_rd();
        cmd_t c;
        int unsigned n;
        clear_logs();
        c.we = 1'b1; c.addr = 25'($urandom); c.wdata = 16'($urandom);
        q0.push_back(c);
        n = 0;
        while (!c0_gnt && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!c0_gnt) begin errors++; $display("FAIL wr_rd_timeout c0_gnt=%b expected=1", c0_gnt); end
        c.we = 1'b0; c.addr = 25'($urandom);
        q1.push_back(c);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            checks++;
            if (obs_ctl !== e_ctl) begin errors++; $display("FAIL wr_rd_ctl cyc=%0d got=%b expected=%b", cyc, obs_ctl, e_ctl); end
            checks++;
            if (obs_dat !== e_dat) begin errors++; $display("FAIL wr_rd_data cyc=%0d got=%h expected=%h", cyc, obs_dat, e_dat); end
        end
        checks++;
        if (gnt_cyc.size() != 2 || wr_cyc.size() != 1 || rd_cyc.size() != 1) begin
            errors++; $display("FAIL wr_rd_count grants=%0d writes=%0d reads=%0d expected=2/1/1",
                               gnt_cyc.size(), wr_cyc.size(), rd_cyc.size());
        end else begin
            checks++;
            if (gnt_who[1] != 1 || gnt_cyc[1] - gnt_cyc[0] != WR_CYCLES + 1 || rd_cyc[0] - wr_cyc[0] != WR_CYCLES + 1) begin
                errors++; $display("FAIL wr_rd_spacing who=%0d gnt_gap=%0d strobe_gap=%0d expected who=1 gap=%0d",
                                   gnt_who[1], gnt_cyc[1] - gnt_cyc[0], rd_cyc[0] - wr_cyc[0], WR_CYCLES + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        int unsigned n;
        clear_logs();
        c.we = 1'b0; c.addr = 25'($urandom); c.wdata = '0;
        q0.push_back(c);
        n = 0;
        while (!read && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!read) begin errors++; $display("FAIL rstmid_timeout read=%b expected=1", read); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (obs_ctl !== 7'b0 || obs_dat !== 82'b0) begin
            errors++; $display("FAIL rstmid_zero ctl=%b data=%h expected all zero", obs_ctl, obs_dat);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs_ctl !== e_ctl) begin errors++; $display("FAIL rstmid_ctl cyc=%0d got=%b expected=%b", cyc, obs_ctl, e_ctl); end
        end
        checks++;
        if (rv_cyc.size() != 0) begin errors++; $display("FAIL rstmid_rvalid count=%0d expected=0", rv_cyc.size()); end
        c.addr = 25'($urandom);
        q1.push_back(c);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (obs_ctl !== e_ctl) begin errors++; $display("FAIL rstmid2_ctl cyc=%0d got=%b expected=%b", cyc, obs_ctl, e_ctl); end
            checks++;
            if (obs_dat !== e_dat) begin errors++; $display("FAIL rstmid2_data cyc=%0d got=%h expected=%h", cyc, obs_dat, e_dat); end
        end
        checks++;
        if (rv_who.size() != 1 || rv_data.size() != 1) begin
            errors++; $display("FAIL rstmid_after rvalids=%0d expected=1", rv_who.size());
        end else if (rv_who[0] != 1 || rv_data[0] !== mem_f(c.addr)) begin
            errors++; $display("FAIL rstmid_after who=%0d data=%h expected who=1 data=%h", rv_who[0], rv_data[0], mem_f(c.addr));
        end
    endtask

    task automatic test_back_to_back();
        cmd_t c;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            c.we = 1'b0; c.addr = 25'(i * 16); c.wdata = '0;
            q1.push_back(c);
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            checks++;
            if (obs_ctl !== e_ctl) begin errors++; $display("FAIL b2b_ctl cyc=%0d got=%b expected=%b", cyc, obs_ctl, e_ctl); end
            checks++;
            if (obs_dat !== e_dat) begin errors++; $display("FAIL b2b_data cyc=%0d got=%h expected=%h", cyc, obs_dat, e_dat); end
        end
        checks++;
        if (rd_cyc.size() != 3 || rv_data.size() != 3) begin
            errors++; $display("FAIL b2b_count reads=%0d rvalids=%0d expected=3/3", rd_cyc.size(), rv_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rv_data[i] !== mem_f(25'(i * 16)) || rv_who[i] != 1) begin
                    errors++; $display("FAIL b2b_rdata idx=%0d got=%h expected=%h", i, rv_data[i], mem_f(25'(i * 16)));
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (rd_cyc[i] - rd_cyc[i-1] != RD_LAT + 1) begin
                    errors++; $display("FAIL b2b_gap idx=%0d got=%0d expected=%0d", i, rd_cyc[i] - rd_cyc[i-1], RD_LAT + 1);
                end
            end
        end
    endtask

    task automatic test_random();
        cmd_t c;
        int unsigned n;
        clear_logs();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                c.we = 1'($urandom_range(0, 1)); c.addr = 25'($urandom); c.wdata = 16'($urandom);
                if ($urandom_range(0, 1) == 0) q0.push_back(c); else q1.push_back(c);
            end
            checks++;
            if (obs_ctl !== e_ctl) begin errors++; $display("FAIL rand_ctl cyc=%0d got=%b expected=%b", cyc, obs_ctl, e_ctl); end
            checks++;
            if (obs_dat !== e_dat) begin errors++; $display("FAIL rand_data cyc=%0d got=%h expected=%h", cyc, obs_dat, e_dat); end
        end
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && n < 800) begin
            @(negedge clk);
            n++;
            checks++;
            if (obs_ctl !== e_ctl) begin errors++; $display("FAIL rand_drain_ctl cyc=%0d got=%b expected=%b", cyc, obs_ctl, e_ctl); end
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL rand_drain pending=%0d/%0d expected=0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_single();
        test_write_single();
        test_both_read();
        test_wr_then_rd();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
